// File: rtl/sramx_responder_pkg.sv
// sramx protocol shared types.
//   sramx_req_t        : one port's request bundle (en, byte wen, byte addr, wdata)
//   sramx_resp_t       : one port's response bundle (rdata)
//   sramx_resp_state_t : responder FSM states
//   in_window()        : window decode on the upper address bits
package sramx_responder_pkg;

    typedef struct packed {
        logic        en;
        logic [3:0]  wen;
        logic [31:0] addr;
        logic [31:0] wdata;
    } sramx_req_t;

    typedef struct packed {
        logic [31:0] rdata;
    } sramx_resp_t;

    typedef enum logic {
        INIT = 1'b0,
        RUN  = 1'b1
    } sramx_resp_state_t;

    // True when addr falls in the aligned window of 2**(aw+2) bytes at base.
    function automatic logic in_window(input logic [31:0] addr,
                                       input logic [31:0] base,
                                       input int          aw);
        return (addr >> (aw + 2)) == (base >> (aw + 2));
    endfunction

endpackage

// File: rtl/sramx_responder_dp_byte_ram.sv
// Dual-port byte-writable word array, read-first on both ports.
//   i_clk              : clock
//   i_a_we/addr/wdata  : port A byte write enables, word index, write data
//   o_a_rdata          : port A combinational read of the pre-edge contents
//   i_b_*, o_b_rdata   : port B, same meaning; B wins on colliding byte lanes
module dp_byte_ram #(
    parameter int ADDR_WIDTH = 12
) (
    input  logic                  i_clk,
    input  logic [3:0]            i_a_we,
    input  logic [ADDR_WIDTH-1:0] i_a_addr,
    input  logic [31:0]           i_a_wdata,
    output logic [31:0]           o_a_rdata,
    input  logic [3:0]            i_b_we,
    input  logic [ADDR_WIDTH-1:0] i_b_addr,
    input  logic [31:0]           i_b_wdata,
    output logic [31:0]           o_b_rdata
);

    localparam int DEPTH = 2 ** ADDR_WIDTH;

    logic [3:0][7:0] r_mem [DEPTH];

    // Reads see the array before this edge's writes; the owner registers them.
    assign o_a_rdata = r_mem[i_a_addr];
    assign o_b_rdata = r_mem[i_b_addr];

    // Port B is assigned after port A, so on a shared word and lane the
    // later non-blocking write (port B) is the one that lands.
    always_ff @(posedge i_clk) begin
        for (int i = 0; i < 4; i++) begin
            if (i_a_we[i]) r_mem[i_a_addr][i] <= i_a_wdata[8*i +: 8];
            if (i_b_we[i]) r_mem[i_b_addr][i] <= i_b_wdata[8*i +: 8];
        end
    end

endmodule

// File: rtl/sramx_responder.sv
// sramx fixed-latency memory responder.
//   clk, reset           : clock, synchronous active-high reset
//   inst_sram_*          : instruction port request in, rdata out (1-cycle latency)
//   data_sram_*          : data port, same; data port wins byte-lane collisions
//   init_done            : array clear sweep finished, requests accepted
//   err_valid, err_addr  : sticky capture of the first out-of-window access
//   err_clear            : clears the capture (a same-cycle fault still wins)
module sramx_responder
    import sramx_responder_pkg::*;
#(
    parameter int          ADDR_WIDTH = 12,
    parameter logic [31:0] BASE_ADDR  = 32'h1fc0_0000,
    parameter logic [31:0] ERR_RDATA  = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        inst_sram_en,
    input  logic [3:0]  inst_sram_wen,
    input  logic [31:0] inst_sram_addr,
    input  logic [31:0] inst_sram_wdata,
    output logic [31:0] inst_sram_rdata,
    input  logic        data_sram_en,
    input  logic [3:0]  data_sram_wen,
    input  logic [31:0] data_sram_addr,
    input  logic [31:0] data_sram_wdata,
    output logic [31:0] data_sram_rdata,
    output logic        init_done,
    output logic        err_valid,
    output logic [31:0] err_addr,
    input  logic        err_clear
);

    sramx_req_t             w_ireq, w_dreq;
    sramx_resp_t            r_iresp, r_dresp;
    sramx_resp_state_t      r_state, w_next;
    logic [ADDR_WIDTH-1:0]  r_cnt;
    logic                   r_init_done;
    logic                   r_err_valid;
    logic [31:0]            r_err_addr;

    logic                   w_run, w_ihit, w_dhit, w_ifault, w_dfault;
    logic [ADDR_WIDTH-1:0]  w_iidx, w_didx, w_b_addr;
    logic [3:0]             w_a_we, w_b_we;
    logic [31:0]            w_b_wdata, w_a_rdata, w_b_rdata;

    assign w_ireq = '{en: inst_sram_en, wen: inst_sram_wen,
                      addr: inst_sram_addr, wdata: inst_sram_wdata};
    assign w_dreq = '{en: data_sram_en, wen: data_sram_wen,
                      addr: data_sram_addr, wdata: data_sram_wdata};

    assign w_run    = (r_state == RUN);
    assign w_ihit   = in_window(w_ireq.addr, BASE_ADDR, ADDR_WIDTH);
    assign w_dhit   = in_window(w_dreq.addr, BASE_ADDR, ADDR_WIDTH);
    assign w_iidx   = w_ireq.addr[ADDR_WIDTH+1:2];
    assign w_didx   = w_dreq.addr[ADDR_WIDTH+1:2];
    assign w_ifault = w_run && w_ireq.en && !w_ihit;
    assign w_dfault = w_run && w_dreq.en && !w_dhit;

    always_ff @(posedge clk) begin
        if (reset) r_state <= INIT;
        else       r_state <= w_next;
    end

    // Next state plus RAM port steering. The clear sweep borrows the data
    // port so the inst port stays a plain request path.
    always_comb begin
        w_next    = r_state;
        w_a_we    = 4'h0;
        w_b_we    = 4'h0;
        w_b_addr  = w_didx;
        w_b_wdata = w_dreq.wdata;
        case (r_state)
            INIT: begin
                w_b_we    = 4'hf;
                w_b_addr  = r_cnt;
                w_b_wdata = 32'h0;
                if (&r_cnt) w_next = RUN;
            end
            RUN: begin
                if (w_ireq.en && w_ihit) w_a_we = w_ireq.wen;
                if (w_dreq.en && w_dhit) w_b_we = w_dreq.wen;
            end
            default: w_next = INIT;
        endcase
    end

    dp_byte_ram #(.ADDR_WIDTH(ADDR_WIDTH)) u_ram (
        .i_clk     (clk),
        .i_a_we    (w_a_we),
        .i_a_addr  (w_iidx),
        .i_a_wdata (w_ireq.wdata),
        .o_a_rdata (w_a_rdata),
        .i_b_we    (w_b_we),
        .i_b_addr  (w_b_addr),
        .i_b_wdata (w_b_wdata),
        .o_b_rdata (w_b_rdata)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            r_cnt       <= '0;
            r_init_done <= 1'b0;
            r_iresp     <= '0;
            r_dresp     <= '0;
            r_err_valid <= 1'b0;
            r_err_addr  <= 32'h0;
        end else begin
            r_init_done <= (w_next == RUN);
            if (r_state == INIT) r_cnt <= r_cnt + 1'b1;

            if (w_run && w_ireq.en) r_iresp.rdata <= w_ihit ? w_a_rdata : ERR_RDATA;
            if (w_run && w_dreq.en) r_dresp.rdata <= w_dhit ? w_b_rdata : ERR_RDATA;

            // A fault is captured when nothing is held, or when the holder is
            // being cleared this cycle; the data port takes precedence.
            if ((w_ifault || w_dfault) && (!r_err_valid || err_clear)) begin
                r_err_valid <= 1'b1;
                r_err_addr  <= w_dfault ? w_dreq.addr : w_ireq.addr;
            end else if (err_clear) begin
                r_err_valid <= 1'b0;
                r_err_addr  <= 32'h0;
            end
        end
    end

    assign inst_sram_rdata = r_iresp.rdata;
    assign data_sram_rdata = r_dresp.rdata;
    assign init_done       = r_init_done;
    assign err_valid       = r_err_valid;
    assign err_addr        = r_err_addr;

endmodule

// File: tb/tb_sramx_responder.sv
module tb_sramx_responder;

    localparam int          AW    = 4;
    localparam int          DEPTH = 16;
    localparam logic [31:0] BASE  = 32'h1fc0_0000;
    localparam logic [31:0] ERRD  = 32'h0000_0000;

    logic        clk = 1'b0;
    logic        reset;
    logic        inst_sram_en, data_sram_en, err_clear;
    logic [3:0]  inst_sram_wen, data_sram_wen;
    logic [31:0] inst_sram_addr, inst_sram_wdata, inst_sram_rdata;
    logic [31:0] data_sram_addr, data_sram_wdata, data_sram_rdata;
    logic        init_done, err_valid;
    logic [31:0] err_addr;

    always #5 clk = ~clk;

    sramx_responder #(.ADDR_WIDTH(AW), .BASE_ADDR(BASE), .ERR_RDATA(ERRD)) dut (
        .clk(clk), .reset(reset),
        .inst_sram_en(inst_sram_en), .inst_sram_wen(inst_sram_wen),
        .inst_sram_addr(inst_sram_addr), .inst_sram_wdata(inst_sram_wdata),
        .inst_sram_rdata(inst_sram_rdata),
        .data_sram_en(data_sram_en), .data_sram_wen(data_sram_wen),
        .data_sram_addr(data_sram_addr), .data_sram_wdata(data_sram_wdata),
        .data_sram_rdata(data_sram_rdata),
        .init_done(init_done), .err_valid(err_valid), .err_addr(err_addr),
        .err_clear(err_clear)
    );

    int checks = 0;
    int errors = 0;

    // Reference model: word array plus observable state.
    logic [31:0] m_mem [DEPTH];
    logic [31:0] m_ird, m_drd, m_ea;
    logic        m_ev, m_run;
    int          m_cnt;

    function automatic logic hit(input logic [31:0] a);
        return (a >> (AW + 2)) == (BASE >> (AW + 2));
    endfunction

    function automatic logic [31:0] waddr(input int idx);
        return BASE + 32'(idx * 4);
    endfunction

    // Drive one cycle of requests, clock it, and advance the model.
    task automatic step(input logic rst,
                        input logic ie, input logic [3:0] iw, input logic [31:0] ia, input logic [31:0] id,
                        input logic de, input logic [3:0] dw, input logic [31:0] da, input logic [31:0] dd,
                        input logic clr);
        logic [31:0] oi, od;
        logic        fi, fd;
        reset = rst;
        inst_sram_en = ie; inst_sram_wen = iw; inst_sram_addr = ia; inst_sram_wdata = id;
        data_sram_en = de; data_sram_wen = dw; data_sram_addr = da; data_sram_wdata = dd;
        err_clear = clr;
        @(posedge clk);
        if (rst) begin
            m_run = 1'b0; m_cnt = 0; m_ird = '0; m_drd = '0; m_ev = 1'b0; m_ea = '0;
        end else if (!m_run) begin
            m_mem[m_cnt] = '0;
            m_cnt++;
            if (m_cnt == DEPTH) m_run = 1'b1;
        end else begin
            oi = m_mem[ia[5:2]];
            od = m_mem[da[5:2]];
            if (ie) m_ird = hit(ia) ? oi : ERRD;
            if (de) m_drd = hit(da) ? od : ERRD;
            for (int b = 0; b < 4; b++)
                if (ie && hit(ia) && iw[b]) m_mem[ia[5:2]][8*b +: 8] = id[8*b +: 8];
            for (int b = 0; b < 4; b++)
                if (de && hit(da) && dw[b]) m_mem[da[5:2]][8*b +: 8] = dd[8*b +: 8];
            fi = ie && !hit(ia);
            fd = de && !hit(da);
            if ((fi || fd) && (!m_ev || clr)) begin
                m_ev = 1'b1;
                m_ea = fd ? da : ia;
            end else if (clr) begin
                m_ev = 1'b0; m_ea = '0;
            end
        end
        #1;
    endtask

    task automatic idle();
        step(0, 0, 4'h0, 32'h0, 32'h0, 0, 4'h0, 32'h0, 32'h0, 0);
    endtask

    task automatic test_reset();
        step(1, 0, 4'h0, 32'h0, 32'h0, 0, 4'h0, 32'h0, 32'h0, 0);
        step(1, 0, 4'h0, 32'h0, 32'h0, 0, 4'h0, 32'h0, 32'h0, 0);
        checks += 5;
        if (inst_sram_rdata !== 32'h0) begin errors++; $display("FAIL reset_irdata got %h want 0", inst_sram_rdata); end
        if (data_sram_rdata !== 32'h0) begin errors++; $display("FAIL reset_drdata got %h want 0", data_sram_rdata); end
        if (init_done !== 1'b0) begin errors++; $display("FAIL reset_init_done got %b want 0", init_done); end
        if (err_valid !== 1'b0) begin errors++; $display("FAIL reset_err_valid got %b want 0", err_valid); end
        if (err_addr !== 32'h0) begin errors++; $display("FAIL reset_err_addr got %h want 0", err_addr); end
        for (int i = 1; i <= DEPTH; i++) begin
            idle();
            checks += 3;
            if (init_done !== (i == DEPTH)) begin
                errors++; $display("FAIL init_done_cycle%0d got %b want %b", i, init_done, i == DEPTH);
            end
            if (inst_sram_rdata !== 32'h0 || data_sram_rdata !== 32'h0) begin
                errors++; $display("FAIL init_rdata_cycle%0d got %h/%h want 0", i, inst_sram_rdata, data_sram_rdata);
            end
            if (init_done !== m_run) begin
                errors++; $display("FAIL init_model_cycle%0d got %b want %b", i, init_done, m_run);
            end
        end
    endtask

    task automatic test_merge();
        step(0, 0, 4'h0, 32'h0, 32'h0, 1, 4'hf, 32'h1fc0_000c, 32'hFFFF_FFFF, 0);
        step(0, 0, 4'h0, 32'h0, 32'h0, 1, 4'b0101, 32'h1fc0_000c, 32'hAABB_CCDD, 0);
        step(0, 1, 4'h0, 32'h1fc0_000c, 32'h0, 0, 4'h0, 32'h0, 32'h0, 0);
        checks += 2;
        if (inst_sram_rdata !== 32'hFFBB_FFDD) begin errors++; $display("FAIL merge_rdata got %h want ffbbffdd", inst_sram_rdata); end
        if (inst_sram_rdata !== m_ird) begin errors++; $display("FAIL merge_model got %h want %h", inst_sram_rdata, m_ird); end
    endtask

    task automatic test_read_first();
        step(0, 1, 4'h0, 32'h1fc0_0008, 32'h0, 1, 4'hf, 32'h1fc0_0008, 32'h1234_5678, 0);
        checks += 1;
        if (inst_sram_rdata !== 32'h0) begin errors++; $display("FAIL read_first_old got %h want 0", inst_sram_rdata); end
        step(0, 1, 4'h0, 32'h1fc0_0008, 32'h0, 0, 4'h0, 32'h0, 32'h0, 0);
        checks += 1;
        if (inst_sram_rdata !== 32'h1234_5678) begin errors++; $display("FAIL read_first_new got %h want 12345678", inst_sram_rdata); end
        idle();
        checks += 1;
        if (inst_sram_rdata !== 32'h1234_5678) begin errors++; $display("FAIL rdata_hold got %h want 12345678", inst_sram_rdata); end
    endtask

    task automatic test_collide();
        step(0, 1, 4'b0011, 32'h1fc0_0014, 32'h1111_1111, 1, 4'b0110, 32'h1fc0_0014, 32'h2222_2222, 0);
        step(0, 0, 4'h0, 32'h0, 32'h0, 1, 4'h0, 32'h1fc0_0014, 32'h0, 0);
        checks += 1;
        if (data_sram_rdata !== 32'h0022_2211) begin errors++; $display("FAIL collide_word5 got %h want 00222211", data_sram_rdata); end
    endtask

    task automatic test_errors();
        step(0, 1, 4'h0, 32'h8000_0000, 32'h0, 1, 4'h0, 32'h0000_0040, 32'h0, 0);
        checks += 4;
        if (inst_sram_rdata !== ERRD) begin errors++; $display("FAIL err_irdata got %h want %h", inst_sram_rdata, ERRD); end
        if (data_sram_rdata !== ERRD) begin errors++; $display("FAIL err_drdata got %h want %h", data_sram_rdata, ERRD); end
        if (err_valid !== 1'b1) begin errors++; $display("FAIL err_valid_set got %b want 1", err_valid); end
        if (err_addr !== 32'h0000_0040) begin errors++; $display("FAIL err_addr_dataprio got %h want 00000040", err_addr); end
        step(0, 1, 4'hf, 32'h0000_0100, 32'hdead_beef, 0, 4'h0, 32'h0, 32'h0, 0);
        checks += 1;
        if (err_addr !== 32'h0000_0040) begin errors++; $display("FAIL err_sticky got %h want 00000040", err_addr); end
        step(0, 0, 4'h0, 32'h0, 32'h0, 1, 4'h0, 32'h0000_0080, 32'h0, 1);
        checks += 2;
        if (err_valid !== 1'b1) begin errors++; $display("FAIL err_clear_fault_valid got %b want 1", err_valid); end
        if (err_addr !== 32'h0000_0080) begin errors++; $display("FAIL err_clear_fault_addr got %h want 00000080", err_addr); end
        step(0, 0, 4'h0, 32'h0, 32'h0, 0, 4'h0, 32'h0, 32'h0, 1);
        checks += 2;
        if (err_valid !== 1'b0) begin errors++; $display("FAIL err_cleared_valid got %b want 0", err_valid); end
        if (err_addr !== 32'h0) begin errors++; $display("FAIL err_cleared_addr got %h want 0", err_addr); end
    endtask

    task automatic rand_req(output logic en, output logic [3:0] wen, output logic [31:0] addr, output logic [31:0] wd);
        en  = $urandom_range(0, 3) != 0;
        wen = 4'($urandom);
        wd  = $urandom;
        if ($urandom_range(0, 7) == 0) addr = $urandom;
        else addr = waddr($urandom_range(0, DEPTH - 1)) | 32'($urandom_range(0, 3));
    endtask

    task automatic test_random();
        logic ie, de, clr;
        logic [3:0] iw, dw;
        logic [31:0] ia, id, da, dd;
        for (int n = 0; n < 300; n++) begin
            rand_req(ie, iw, ia, id);
            rand_req(de, dw, da, dd);
            clr = $urandom_range(0, 7) == 0;
            step(0, ie, iw, ia, id, de, dw, da, dd, clr);
            checks += 4;
            if (inst_sram_rdata !== m_ird) begin errors++; $display("FAIL rand%0d_irdata got %h want %h", n, inst_sram_rdata, m_ird); end
            if (data_sram_rdata !== m_drd) begin errors++; $display("FAIL rand%0d_drdata got %h want %h", n, data_sram_rdata, m_drd); end
            if (err_valid !== m_ev) begin errors++; $display("FAIL rand%0d_err_valid got %b want %b", n, err_valid, m_ev); end
            if (err_addr !== m_ea) begin errors++; $display("FAIL rand%0d_err_addr got %h want %h", n, err_addr, m_ea); end
        end
    endtask

    task automatic test_reset_mid();
        logic ie, de;
        logic [3:0] iw, dw;
        logic [31:0] ia, id, da, dd;
        step(0, 0, 4'h0, 32'h0, 32'h0, 1, 4'hf, 32'h1fc0_001c, 32'hCAFE_F00D, 0);
        step(1, 0, 4'h0, 32'h0, 32'h0, 0, 4'h0, 32'h0, 32'h0, 0);
        for (int i = 1; i <= DEPTH; i++) begin
            rand_req(ie, iw, ia, id);
            rand_req(de, dw, da, dd);
            if (i == 3) begin ia = 32'h8000_0000; ie = 1'b1; end
            step(0, ie, iw, ia, id, de, dw, da, dd, 0);
            checks += 3;
            if (init_done !== (i == DEPTH)) begin errors++; $display("FAIL rinit_done_cycle%0d got %b want %b", i, init_done, i == DEPTH); end
            if (inst_sram_rdata !== 32'h0 || data_sram_rdata !== 32'h0) begin
                errors++; $display("FAIL rinit_rdata_cycle%0d got %h/%h want 0", i, inst_sram_rdata, data_sram_rdata);
            end
            if (err_valid !== 1'b0) begin errors++; $display("FAIL rinit_err_cycle%0d got %b want 0", i, err_valid); end
        end
        step(0, 1, 4'h0, 32'h1fc0_001c, 32'h0, 0, 4'h0, 32'h0, 32'h0, 0);
        checks += 1;
        if (inst_sram_rdata !== 32'h0) begin errors++; $display("FAIL word7_cleared got %h want 0", inst_sram_rdata); end
        for (int w = 0; w < DEPTH; w++) begin
            step(0, 0, 4'h0, 32'h0, 32'h0, 1, 4'h0, waddr(w), 32'h0, 0);
            checks += 1;
            if (data_sram_rdata !== m_drd || m_drd !== 32'h0) begin
                errors++; $display("FAIL sweep_word%0d got %h want 0", w, data_sram_rdata);
            end
        end
    endtask

    initial begin
        test_reset();
        test_merge();
        test_read_first();
        test_collide();
        test_errors();
        test_random();
        test_reset_mid();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/sramx_responder.md
# sramx_responder

Memory-side responder for the sramx fixed-latency protocol: it receives the `inst_sram_*` and `data_sram_*` requests that the core top drives and returns read data one cycle later from a shared, byte-writable word array. It serves as the on-chip memory behind the core in simulation and FPGA builds. It also clears the array after reset and records the first out-of-window access for debug.

## Interface
- `ADDR_WIDTH`, default 12: word-index bits; depth = 2**ADDR_WIDTH words.
- `BASE_ADDR`, default 32'h1fc0_0000: physical base of the window; must be aligned to 2**(ADDR_WIDTH+2).
- `ERR_RDATA`, default 32'h0000_0000: read data returned for out-of-window reads.
- `clk`  in  1  clock; one clock domain.
- `reset`  in  1  synchronous, active-high reset.
- `inst_sram_en`  in  1  instruction-port request.
- `inst_sram_wen`  in  4  instruction-port byte write enables.
- `inst_sram_addr`  in  32  instruction-port physical byte address.
- `inst_sram_wdata`  in  32  instruction-port write data.
- `inst_sram_rdata`  out  32  instruction-port read data.
- `data_sram_en` / `_wen` / `_addr` / `_wdata` / `_rdata`: same widths and meanings for the data port.
- `init_done`  out  1  array cleared; requests are accepted.
- `err_valid`  out  1  sticky flag for an out-of-window access.
- `err_addr`  out  32  address of the first out-of-window access.
- `err_clear`  in  1  clears `err_valid` and `err_addr`.

## Operation
- FSM states are `INIT` and `RUN`. `reset` forces `INIT` and sets the clear counter to 0.
- `INIT`:
  - Each cycle, write 0 to word[counter] and increment the counter.
  - After writing word 2**ADDR_WIDTH-1, go to `RUN`.
  - All port requests are ignored: no writes, no errors.
  - Both `rdata` outputs stay 0.
- `RUN` in-window test: a port with `en`=1 is in-window when `addr[31:ADDR_WIDTH+2]` == `BASE_ADDR[31:ADDR_WIDTH+2]`. The index is `addr[ADDR_WIDTH+1:2]`. `addr[1:0]` is ignored.
- `RUN`, in-window request:
  - The read is read-first: `rdata` takes the word value from before this cycle's writes.
  - Byte lane i is written with `wdata[8i+7:8i]` when `wen[i]`=1.
- `RUN`, out-of-window request:
  - No write occurs; `rdata` = ERR_RDATA on the next cycle.
  - If `err_valid`=0: set `err_valid`=1 and capture the address into `err_addr`.
  - If both ports fault in the same cycle, `err_addr` takes the data-port address.
- Both ports write the same word in the same cycle:
  - Non-overlapping byte lanes merge.
  - Overlapping lanes take the data-port byte.
- When `en`=0, that port's `rdata` holds its previous value.
- `err_clear`=1: `err_valid` and `err_addr` return to 0 next cycle. If a new fault occurs in the same cycle, the fault wins: it sets `err_valid` and captures the new address.
- Both ports are fully independent; neither stalls the other.

## Timing
- Reset values: `inst_sram_rdata`=0, `data_sram_rdata`=0, `init_done`=0, `err_valid`=0, `err_addr`=0.
- Initialization takes exactly 2**ADDR_WIDTH cycles after `reset` deasserts. `init_done` is registered and rises in the cycle after the last clear write.
- A request presented in the first cycle with `init_done`=1 is served.
- Read latency is 1 cycle: request at edge N gives `rdata` valid after edge N+1, held until the next request on that port.
- A write at edge N is visible to a read at edge N+1 on either port; there is no bypass within the same cycle.
- `reset` asserted mid-`INIT` or mid-`RUN` restarts `INIT`, and the clear sweep runs again in full.
- `err_valid` and `err_addr` update one cycle after the faulting request.

## Structure
- Extend the existing sramx header:
  - Reuse `sramx_req_t` and `sramx_resp_t` for port bundling internally.
  - Add the `sramx_resp_state_t` enum {INIT, RUN}.
- Sub-module `dp_byte_ram`: 2**ADDR_WIDTH × 32 array with two read-first ports, per-byte write enables, and data-port priority on lane collision. The top holds the FSM, clear counter, window decode, error capture and `rdata` registers.

## Test plan
All scenarios use ADDR_WIDTH=4 (16 words) and BASE_ADDR=32'h1fc0_0000.
- Reset then idle → `init_done`=0 for exactly 16 cycles, then 1; both `rdata`=0 throughout.
- Pre-fill word 3 with 32'hFFFF_FFFF. Data write addr 32'h1fc0_000c, wen 4'b0101, wdata 32'hAABB_CCDD; then inst read of the same address → next-cycle `inst_sram_rdata`=32'hFFBB_FFDD.
- Same cycle: data write 32'h1234_5678 (wen 4'hf) and inst read, both to word 2 (pre-cleared) → inst `rdata`=0. Reread next cycle → 32'h1234_5678.
- Same cycle, both ports write word 5: inst wen 4'b0011 wdata 32'h1111_1111, data wen 4'b0110 wdata 32'h2222_2222 → word 5 = 32'h0022_2211.
- Same cycle: data read 32'h0000_0040 and inst read 32'h8000_0000 → both `rdata`=ERR_RDATA, `err_valid`=1, `err_addr`=32'h0000_0040. A later fault does not change `err_addr`. `err_clear` together with a new fault at 32'h0000_0080 → `err_addr`=32'h0000_0080.
- Write word 7, assert `reset` for 1 cycle mid-stream → `init_done` low for 16 cycles; word 7 then reads 0; requests issued during `INIT` cause no writes and no errors.
